iq_stream_packetizer: RTL



---
 rtl/iq_stream_packetizer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/iq_stream_packetizer.sv
// iq_stream_packetizer: buffers I/Q pairs and emits header+payload AXI-Stream packets.
// Define IQ_PACKETIZER_DROP_ON_FULL_EN to accept input unconditionally and count samples dropped on full.
module iq_stream_packetizer #(
    parameter int IQ_WIDTH = 18,
    parameter int PKT_SAMPLES = 256,
    parameter int FIFO_DEPTH = 512,
    parameter logic [7:0] SYNC_WORD = 8'hC5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [IQ_WIDTH-1:0]           in_i,
    input  logic [IQ_WIDTH-1:0]           in_q,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [63:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count,
    output logic [15:0]                   status
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t                  state;
    logic [2*IQ_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           beat;
    logic [15:0]             seq;
    logic                    full, empty, pop, wr, ovf_seen;
    logic signed [IQ_WIDTH-1:0] rd_i, rd_q;
    logic [63:0]             payload;

    assign full  = fifo_level == LW'(FIFO_DEPTH);
    assign empty = fifo_level == '0;
    // The output register is refilled from the FIFO on each accepted non-final word.
    assign pop   = m_tready && (state == HEADER || (state == PAYLOAD && !m_tlast));
    assign wr    = in_valid && in_ready && (!full || pop);
    assign {rd_i, rd_q} = mem[rd_ptr];
    assign payload = {32'(rd_i), 32'(rd_q)};
    assign status  = {12'h000, ovf_seen, empty, full, state != IDLE};

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {in_i, in_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(wr) - LW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            beat     <= '0;
            seq      <= '0;
        end else begin
            case (state)
                IDLE: if (enable && fifo_level >= LW'(PKT_SAMPLES) && !m_tvalid) begin
                    state    <= HEADER;
                    m_tvalid <= 1'b1;
                    m_tlast  <= 1'b0;
                    m_tdata  <= {SYNC_WORD, 8'h00, seq, 32'(PKT_SAMPLES)};
                end
                HEADER: if (m_tready) begin
                    state   <= PAYLOAD;
                    m_tdata <= payload;
                    m_tlast <= PKT_SAMPLES == 1;
                    beat    <= '0;
                end
                PAYLOAD: if (m_tready) begin
                    if (m_tlast) begin
                        state    <= IDLE;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        m_tdata  <= '0;
                        seq      <= seq + 1'b1;
                    end else begin
                        m_tdata <= payload;
                        beat    <= beat + 1'b1;
                        m_tlast <= beat + 1'b1 == LW'(PKT_SAMPLES - 1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IQ_PACKETIZER_DROP_ON_FULL_EN
    assign in_ready = enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_count <= '0;
            ovf_seen       <= 1'b0;
        end else if (in_valid && enable && full && !pop) begin
            overflow_count <= overflow_count == 16'hFFFF ? overflow_count : overflow_count + 1'b1;
            ovf_seen       <= 1'b1;
        end
    end
`else
    assign in_ready       = enable && !full;
    assign overflow_count = '0;
    assign ovf_seen       = 1'b0;
`endif

endmodule
